// File: rtl/car_traffic_ctrl.sv
// -----------------------------------------------------------------------------
// car_traffic_ctrl
//
// Produces the four car positions for the sprite display stage. An internal
// frame timer raises a tick once per frame; on each tick in RUN every lane
// divider advances and, when it expires, its car steps STEP_PX pixels left or
// right with wrap-around at the screen edges. Lanes 1 and 3 move right, lanes 2
// and 4 move left; the base period of lane k is k+1 frames, shortened by the
// speed level.
//
// Optional feature macro: COLLISION_DETECT_EN
//   defined   : frog/car overlap is checked one cycle after each frame tick;
//               an overlap pulses o_Collision and freezes traffic (HIT) for
//               HIT_FRAMES frames, after which i_Run selects RUN or PAUSE.
//   undefined : no overlap logic, no HIT state, o_Collision = o_Hit = 0 and
//               the frog inputs are ignored.
//
// Ports
//   i_Clk                 pixel clock
//   i_Rst                 synchronous active-high reset
//   i_Run                 1 = traffic may move, 0 = pause request
//   i_Level[1:0]          speed level, 0 slowest .. 3 fastest
//   i_Frog_X/Y[9:0]       frog top-left corner
//   o_Car_nX_Position     car n top-left X (registered)
//   o_Car_nY_Position     car n top-left Y (constant per lane)
//   o_Frame_Tick          one-cycle pulse per frame
//   o_Collision           one-cycle pulse on a detected overlap
//   o_Hit                 high while traffic is frozen after a collision
// -----------------------------------------------------------------------------
module car_traffic_ctrl #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int TILE_SIZE      = 32,
  parameter int FRAME_CYCLES   = 420000,
  parameter int LANE_Y_BASE    = 96,
  parameter int STEP_PX        = 8,
  parameter int HIT_FRAMES     = 60
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Run,
  input  logic [1:0] i_Level,
  input  logic [9:0] i_Frog_X,
  input  logic [9:0] i_Frog_Y,
  output logic [9:0] o_Car_1X_Position,
  output logic [9:0] o_Car_2X_Position,
  output logic [9:0] o_Car_3X_Position,
  output logic [9:0] o_Car_4X_Position,
  output logic [9:0] o_Car_1Y_Position,
  output logic [9:0] o_Car_2Y_Position,
  output logic [9:0] o_Car_3Y_Position,
  output logic [9:0] o_Car_4Y_Position,
  output logic       o_Frame_Tick,
  output logic       o_Collision,
  output logic       o_Hit
);

  localparam int FCW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_CYCLES - 1);

  localparam logic [10:0] X_MAX = 11'(H_VISIBLE_AREA - TILE_SIZE);
  localparam logic [10:0] STEP  = 11'(STEP_PX);
  localparam logic [10:0] TILE  = 11'(TILE_SIZE);

  // Cars start evenly spread across the screen.
  localparam logic [3:0][9:0] CAR_X_INIT = {
    10'(3 * H_VISIBLE_AREA / 4),
    10'(H_VISIBLE_AREA / 2),
    10'(H_VISIBLE_AREA / 4),
    10'd0
  };

  localparam logic [3:0][9:0] LANE_Y = {
    10'(LANE_Y_BASE + 3 * TILE_SIZE),
    10'(LANE_Y_BASE + 2 * TILE_SIZE),
    10'(LANE_Y_BASE + TILE_SIZE),
    10'(LANE_Y_BASE)
  };

`ifdef COLLISION_DETECT_EN
  typedef enum logic [1:0] {PAUSE, RUN, HIT} state_t;
  localparam int HCW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam logic [HCW-1:0] HIT_LAST = HCW'(HIT_FRAMES - 1);
`else
  typedef enum logic {PAUSE, RUN} state_t;
`endif

  logic [FCW-1:0]   frame_cnt_reg;
  logic             frame_tick_reg;
  state_t           state_reg;
  logic [3:0][9:0]  car_x_reg;
  logic [3:0][2:0]  div_reg;
  logic [3:0][9:0]  car_x_next;
  logic [3:0]       move;
  logic             tick_cond;

`ifdef COLLISION_DETECT_EN
  logic [HCW-1:0]   hit_cnt_reg;
  logic             collision_reg;
  logic             hit_reg;
  logic [3:0]       overlap;
  logic [10:0]      fx;
  logic [10:0]      fy;

  assign fx = {1'b0, i_Frog_X};
  assign fy = {1'b0, i_Frog_Y};
`else
  logic             unused_inputs;
  assign unused_inputs = ^{i_Frog_X, i_Frog_Y, 1'(HIT_FRAMES)};
`endif

  assign tick_cond = (frame_cnt_reg == FRAME_LAST);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    // Effective period minus one: max(0, k - level), i.e. max(1, k+1-level)-1.
    localparam logic [2:0] PERIOD_M1 = 3'(gi);
    logic [2:0]  eff_m1;
    logic [10:0] cx;

    assign cx     = {1'b0, car_x_reg[gi]};
    assign eff_m1 = (PERIOD_M1 > {1'b0, i_Level}) ? (PERIOD_M1 - {1'b0, i_Level}) : 3'd0;
    // >= rather than == so a level increase expires a partly counted divider
    // on the very next tick.
    assign move[gi] = (div_reg[gi] >= eff_m1);

    if ((gi % 2) == 0) begin : g_right
      logic [10:0] sum;
      assign sum = cx + STEP;
      assign car_x_next[gi] = (sum > X_MAX) ? 10'd0 : sum[9:0];
    end else begin : g_left
      assign car_x_next[gi] = (cx < STEP) ? X_MAX[9:0] : (car_x_reg[gi] - STEP[9:0]);
    end

`ifdef COLLISION_DETECT_EN
    localparam logic [10:0] CY = {1'b0, LANE_Y[gi]};
    assign overlap[gi] = (fx < cx + TILE) && (cx < fx + TILE) &&
                         (fy < CY + TILE) && (CY < fy + TILE);
`endif
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      frame_cnt_reg  <= '0;
      frame_tick_reg <= 1'b0;
      state_reg      <= PAUSE;
      car_x_reg      <= CAR_X_INIT;
      div_reg        <= '0;
`ifdef COLLISION_DETECT_EN
      hit_cnt_reg    <= '0;
      collision_reg  <= 1'b0;
      hit_reg        <= 1'b0;
`endif
    end else begin
      frame_cnt_reg  <= tick_cond ? '0 : frame_cnt_reg + FCW'(1);
      frame_tick_reg <= tick_cond;
`ifdef COLLISION_DETECT_EN
      collision_reg  <= 1'b0;
`endif
      case (state_reg)
        PAUSE: begin
          if (tick_cond && i_Run) state_reg <= RUN;
        end
        RUN: begin
          if (tick_cond) begin
            for (int k = 0; k < 4; k++) begin
              if (move[k]) begin
                car_x_reg[k] <= car_x_next[k];
                div_reg[k]   <= 3'd0;
              end else begin
                div_reg[k]   <= div_reg[k] + 3'd1;
              end
            end
            if (!i_Run) state_reg <= PAUSE;
          end
`ifdef COLLISION_DETECT_EN
          // The cycle after the tick sees the freshly stepped positions.
          else if (frame_tick_reg && (|overlap)) begin
            state_reg     <= HIT;
            hit_cnt_reg   <= '0;
            collision_reg <= 1'b1;
            hit_reg       <= 1'b1;
          end
`endif
        end
`ifdef COLLISION_DETECT_EN
        HIT: begin
          if (tick_cond) begin
            if (hit_cnt_reg == HIT_LAST) begin
              state_reg <= i_Run ? RUN : PAUSE;
              hit_reg   <= 1'b0;
            end else begin
              hit_cnt_reg <= hit_cnt_reg + HCW'(1);
            end
          end
        end
`endif
        default: state_reg <= PAUSE;
      endcase
    end
  end

  assign o_Car_1X_Position = car_x_reg[0];
  assign o_Car_2X_Position = car_x_reg[1];
  assign o_Car_3X_Position = car_x_reg[2];
  assign o_Car_4X_Position = car_x_reg[3];
  assign o_Car_1Y_Position = LANE_Y[0];
  assign o_Car_2Y_Position = LANE_Y[1];
  assign o_Car_3Y_Position = LANE_Y[2];
  assign o_Car_4Y_Position = LANE_Y[3];
  assign o_Frame_Tick      = frame_tick_reg;
`ifdef COLLISION_DETECT_EN
  assign o_Collision       = collision_reg;
  assign o_Hit             = hit_reg;
`else
  assign o_Collision       = 1'b0;
  assign o_Hit             = 1'b0;
`endif

endmodule

// File: tb/tb_car_traffic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_traffic_ctrl
//
// Bench for car_traffic_ctrl with FRAME_CYCLES=16 and HIT_FRAMES=3. Before each
// frame tick a behavioural model computes the expected car positions and the
// collision/hit flags and pushes them into a scoreboard queue; each scenario
// task pops the entry when the DUT pulses o_Frame_Tick and compares. Fixed
// positions worked out by hand are checked at key points as well.
// Works with or without COLLISION_DETECT_EN defined.
// -----------------------------------------------------------------------------
module tb_car_traffic_ctrl;

  localparam int T_FRAME = 16;
  localparam int HIT_N   = 3;
  localparam int XMAX    = 608;
  localparam int STEP    = 8;
  localparam int TILE    = 32;
  localparam int YBASE   = 96;
`ifdef COLLISION_DETECT_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  localparam int ST_PAUSE = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_HIT   = 2;

  typedef struct {
    logic [39:0] x;
    logic        coll;
    logic        hit;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Run = 1'b0;
  logic [1:0] i_Level = 2'd0;
  logic [9:0] i_Frog_X = 10'd0;
  logic [9:0] i_Frog_Y = 10'd400;
  logic [9:0] o_Car_1X_Position, o_Car_2X_Position, o_Car_3X_Position, o_Car_4X_Position;
  logic [9:0] o_Car_1Y_Position, o_Car_2Y_Position, o_Car_3Y_Position, o_Car_4Y_Position;
  logic       o_Frame_Tick, o_Collision, o_Hit;

  int checks   = 0;
  int failures = 0;
  int frame_no = 0;

  exp_t sb[$];
  int   m_x[4];
  int   m_div[4];
  int   m_state;
  int   m_hitcnt;

  car_traffic_ctrl #(
    .H_VISIBLE_AREA(640),
    .TILE_SIZE     (TILE),
    .FRAME_CYCLES  (T_FRAME),
    .LANE_Y_BASE   (YBASE),
    .STEP_PX       (STEP),
    .HIT_FRAMES    (HIT_N)
  ) dut (
    .i_Clk            (clk),
    .i_Rst            (i_Rst),
    .i_Run            (i_Run),
    .i_Level          (i_Level),
    .i_Frog_X         (i_Frog_X),
    .i_Frog_Y         (i_Frog_Y),
    .o_Car_1X_Position(o_Car_1X_Position),
    .o_Car_2X_Position(o_Car_2X_Position),
    .o_Car_3X_Position(o_Car_3X_Position),
    .o_Car_4X_Position(o_Car_4X_Position),
    .o_Car_1Y_Position(o_Car_1Y_Position),
    .o_Car_2Y_Position(o_Car_2Y_Position),
    .o_Car_3Y_Position(o_Car_3Y_Position),
    .o_Car_4Y_Position(o_Car_4Y_Position),
    .o_Frame_Tick     (o_Frame_Tick),
    .o_Collision      (o_Collision),
    .o_Hit            (o_Hit)
  );

  always #20 clk = ~clk;

  function automatic logic [39:0] car_x_obs();
    return {o_Car_4X_Position, o_Car_3X_Position, o_Car_2X_Position, o_Car_1X_Position};
  endfunction

  function automatic logic [39:0] model_x();
    return {10'(m_x[3]), 10'(m_x[2]), 10'(m_x[1]), 10'(m_x[0])};
  endfunction

  task automatic model_reset();
    m_x[0] = 0; m_x[1] = 160; m_x[2] = 320; m_x[3] = 480;
    for (int k = 0; k < 4; k++) m_div[k] = 0;
    m_state  = ST_PAUSE;
    m_hitcnt = 0;
  endtask

  // Advance the model across one frame tick using the inputs now applied,
  // then push the expected post-tick result.
  task automatic push_expected();
    exp_t e;
    int   eff;
    bit   coll;
    coll = 1'b0;
    case (m_state)
      ST_PAUSE: if (i_Run) m_state = ST_RUN;
      ST_RUN: begin
        for (int k = 0; k < 4; k++) begin
          eff = (k + 1) - int'(i_Level);
          if (eff < 1) eff = 1;
          if (m_div[k] >= eff - 1) begin
            m_div[k] = 0;
            if (k % 2 == 0) begin
              m_x[k] = m_x[k] + STEP;
              if (m_x[k] > XMAX) m_x[k] = 0;
            end else begin
              if (m_x[k] < STEP) m_x[k] = XMAX;
              else m_x[k] = m_x[k] - STEP;
            end
          end else begin
            m_div[k] = m_div[k] + 1;
          end
        end
        if (!i_Run) m_state = ST_PAUSE;
      end
      default: begin
        if (m_hitcnt == HIT_N - 1) m_state = i_Run ? ST_RUN : ST_PAUSE;
        else m_hitcnt = m_hitcnt + 1;
      end
    endcase
    if (COLL_EN && m_state == ST_RUN) begin
      for (int k = 0; k < 4; k++) begin
        if (int'(i_Frog_X) < m_x[k] + TILE && m_x[k] < int'(i_Frog_X) + TILE &&
            int'(i_Frog_Y) < YBASE + k * TILE + TILE && YBASE + k * TILE < int'(i_Frog_Y) + TILE)
          coll = 1'b1;
      end
      if (coll) begin
        m_state  = ST_HIT;
        m_hitcnt = 0;
      end
    end
    e.x    = model_x();
    e.coll = coll;
    e.hit  = (m_state == ST_HIT);
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next o_Frame_Tick, sampled on negedges.
  task automatic wait_frame_tick(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 40) begin
      @(negedge clk);
      waited++;
      if (o_Frame_Tick === 1'b1) ok = 1'b1;
    end
    $display("frame %0d: tick=%0b car_x=%0d %0d %0d %0d hit=%0b", frame_no, ok,
             o_Car_1X_Position, o_Car_2X_Position, o_Car_3X_Position, o_Car_4X_Position, o_Hit);
    frame_no++;
  endtask

  task automatic test_reset();
    exp_t e;
    bit   ok;
    int   waited;
    i_Run = 1'b0;
    i_Rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_Rst = 1'b0;
    model_reset();
    checks++;
    if (car_x_obs() !== {10'd480, 10'd320, 10'd160, 10'd0}) begin
      failures++; $display("FAIL reset_x got=%h required=%h", car_x_obs(), {10'd480, 10'd320, 10'd160, 10'd0});
    end
    checks++;
    if ({o_Car_4Y_Position, o_Car_3Y_Position, o_Car_2Y_Position, o_Car_1Y_Position} !==
        {10'd192, 10'd160, 10'd128, 10'd96}) begin
      failures++; $display("FAIL reset_y got=%0d/%0d/%0d/%0d required=96/128/160/192",
                           o_Car_1Y_Position, o_Car_2Y_Position, o_Car_3Y_Position, o_Car_4Y_Position);
    end
    checks++;
    if ({o_Frame_Tick, o_Collision, o_Hit} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got=%b required=000", {o_Frame_Tick, o_Collision, o_Hit});
    end
    for (int i = 0; i < 2; i++) begin
      push_expected();
      wait_frame_tick(ok, waited);
      e = sb.pop_front();
      checks++;
      if (!ok || (i == 0 && waited != T_FRAME)) begin
        failures++; $display("FAIL reset_tick_timing tick=%0d got_wait=%0d ok=%0b required_wait=%0d", i, waited, ok, T_FRAME);
      end
      checks++;
      if (car_x_obs() !== e.x) begin
        failures++; $display("FAIL reset_hold_x tick=%0d got=%h required=%h", i, car_x_obs(), e.x);
      end
      @(negedge clk);
      checks++;
      if ({o_Frame_Tick, o_Collision, o_Hit} !== {1'b0, e.coll, e.hit}) begin
        failures++; $display("FAIL reset_hold_flags tick=%0d got=%b required=%b", i, {o_Frame_Tick, o_Collision, o_Hit}, {1'b0, e.coll, e.hit});
      end
    end
  endtask

  task automatic test_rates();
    exp_t e;
    bit   ok;
    int   waited;
    i_Run   = 1'b1;
    i_Level = 2'd0;
    // One tick to enter RUN, then 13 running ticks.
    for (int i = 0; i < 14; i++) begin
      push_expected();
      wait_frame_tick(ok, waited);
      e = sb.pop_front();
      checks++;
      if (!ok || waited != T_FRAME - 1) begin
        failures++; $display("FAIL rates_tick_period tick=%0d got_wait=%0d ok=%0b required_wait=%0d", i, waited, ok, T_FRAME - 1);
      end
      checks++;
      if (car_x_obs() !== e.x) begin
        failures++; $display("FAIL rates_x tick=%0d got=%h required=%h", i, car_x_obs(), e.x);
      end
      @(negedge clk);
      checks++;
      if ({o_Frame_Tick, o_Collision, o_Hit} !== {1'b0, e.coll, e.hit}) begin
        failures++; $display("FAIL rates_flags tick=%0d got=%b required=%b", i, {o_Frame_Tick, o_Collision, o_Hit}, {1'b0, e.coll, e.hit});
      end
    end
    checks++;
    if (car_x_obs() !== {10'd456, 10'd352, 10'd112, 10'd104}) begin
      failures++; $display("FAIL rates_after13 got=%h required=%h", car_x_obs(), {10'd456, 10'd352, 10'd112, 10'd104});
    end
  endtask

  task automatic test_level();
    exp_t e;
    bit   ok;
    int   waited;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) i_Level = 2'd3;
      push_expected();
      wait_frame_tick(ok, waited);
      e = sb.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL level_tick_timeout tick=%0d got_wait=%0d required=tick", i, waited);
      end
      checks++;
      if (car_x_obs() !== e.x) begin
        failures++; $display("FAIL level_x tick=%0d got=%h required=%h", i, car_x_obs(), e.x);
      end
      @(negedge clk);
      checks++;
      if ({o_Frame_Tick, o_Collision, o_Hit} !== {1'b0, e.coll, e.hit}) begin
        failures++; $display("FAIL level_flags tick=%0d got=%b required=%b", i, {o_Frame_Tick, o_Collision, o_Hit}, {1'b0, e.coll, e.hit});
      end
      if (i == 0) begin
        checks++;
        if (car_x_obs() !== {10'd456, 10'd352, 10'd104, 10'd112}) begin
          failures++; $display("FAIL level_before got=%h required=%h", car_x_obs(), {10'd456, 10'd352, 10'd104, 10'd112});
        end
      end
    end
    // Car4 divider stood at 2; level 3 makes it expire immediately.
    checks++;
    if (car_x_obs() !== {10'd448, 10'd360, 10'd96, 10'd120}) begin
      failures++; $display("FAIL level_jump got=%h required=%h", car_x_obs(), {10'd448, 10'd360, 10'd96, 10'd120});
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    bit   ok;
    int   waited;
    for (int i = 1; i <= 62; i++) begin
      push_expected();
      wait_frame_tick(ok, waited);
      e = sb.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL wrap_tick_timeout tick=%0d got_wait=%0d required=tick", i, waited);
      end
      checks++;
      if (car_x_obs() !== e.x) begin
        failures++; $display("FAIL wrap_x tick=%0d got=%h required=%h", i, car_x_obs(), e.x);
      end
      if (i == 11 || i == 12 || i == 13) begin
        checks++;
        if (o_Car_2X_Position !== ((i == 11) ? 10'd8 : (i == 12) ? 10'd0 : 10'd608)) begin
          failures++; $display("FAIL wrap_car2 tick=%0d got=%0d required=%0d", i, o_Car_2X_Position, (i == 11) ? 8 : (i == 12) ? 0 : 608);
        end
      end
      if (i == 61 || i == 62) begin
        checks++;
        if (o_Car_1X_Position !== ((i == 61) ? 10'd608 : 10'd0)) begin
          failures++; $display("FAIL wrap_car1 tick=%0d got=%0d required=%0d", i, o_Car_1X_Position, (i == 61) ? 608 : 0);
        end
      end
      @(negedge clk);
      checks++;
      if ({o_Frame_Tick, o_Collision, o_Hit} !== {1'b0, e.coll, e.hit}) begin
        failures++; $display("FAIL wrap_flags tick=%0d got=%b required=%b", i, {o_Frame_Tick, o_Collision, o_Hit}, {1'b0, e.coll, e.hit});
      end
    end
    checks++;
    if (car_x_obs() !== {10'd568, 10'd240, 10'd216, 10'd0}) begin
      failures++; $display("FAIL wrap_final got=%h required=%h", car_x_obs(), {10'd568, 10'd240, 10'd216, 10'd0});
    end
  endtask

  task automatic test_collision();
    exp_t e;
    bit   ok;
    int   waited;
    // Steps: 0 = hit with run held, 1-3 frozen, 4 resume, 5 second hit,
    // 6-8 frozen with run dropped, 9 paused.
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        i_Frog_X = 10'd8; i_Frog_Y = 10'd96; i_Run = 1'b1;
      end else if (i == 5) begin
        i_Frog_X = 10'(m_x[0]); i_Frog_Y = 10'd96;
      end else begin
        i_Frog_X = 10'd0; i_Frog_Y = 10'd400;
      end
      if (i >= 6) i_Run = 1'b0;
      push_expected();
      wait_frame_tick(ok, waited);
      e = sb.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL coll_tick_timeout step=%0d got_wait=%0d required=tick", i, waited);
      end
      checks++;
      if (car_x_obs() !== e.x) begin
        failures++; $display("FAIL coll_x step=%0d got=%h required=%h", i, car_x_obs(), e.x);
      end
      @(negedge clk);
      checks++;
      if ({o_Frame_Tick, o_Collision, o_Hit} !== {1'b0, e.coll, e.hit}) begin
        failures++; $display("FAIL coll_flags step=%0d got=%b required=%b", i, {o_Frame_Tick, o_Collision, o_Hit}, {1'b0, e.coll, e.hit});
      end
      if (i == 0) begin
        checks++;
        if ({o_Car_1X_Position, o_Collision, o_Hit} !== {10'd8, COLL_EN, COLL_EN}) begin
          failures++; $display("FAIL coll_entry got_x=%0d coll=%b hit=%b required_x=8 coll=%b hit=%b",
                               o_Car_1X_Position, o_Collision, o_Hit, COLL_EN, COLL_EN);
        end
        @(negedge clk);
        checks++;
        if (o_Collision !== 1'b0) begin
          failures++; $display("FAIL coll_pulse_width got=%b required=0", o_Collision);
        end
      end
      if (i == 3) begin
        checks++;
        if (o_Car_1X_Position !== (COLL_EN ? 10'd8 : 10'd32)) begin
          failures++; $display("FAIL coll_freeze got=%0d required=%0d", o_Car_1X_Position, COLL_EN ? 8 : 32);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    int   waited;
    i_Run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_expected();
      wait_frame_tick(ok, waited);
      e = sb.pop_front();
      checks++;
      if (!ok || car_x_obs() !== e.x) begin
        failures++; $display("FAIL midrst_pre_x tick=%0d ok=%0b got=%h required=%h", i, ok, car_x_obs(), e.x);
      end
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    i_Rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_Rst = 1'b0;
    model_reset();
    checks++;
    if ({car_x_obs(), o_Frame_Tick, o_Collision, o_Hit} !== {10'd480, 10'd320, 10'd160, 10'd0, 3'b000}) begin
      failures++; $display("FAIL midrst_values got_x=%h flags=%b required_x=%h flags=000",
                           car_x_obs(), {o_Frame_Tick, o_Collision, o_Hit}, {10'd480, 10'd320, 10'd160, 10'd0});
    end
    for (int i = 0; i < 2; i++) begin
      push_expected();
      wait_frame_tick(ok, waited);
      e = sb.pop_front();
      checks++;
      if (!ok || (i == 0 && waited != T_FRAME)) begin
        failures++; $display("FAIL midrst_tick_timing tick=%0d got_wait=%0d ok=%0b required_wait=%0d", i, waited, ok, T_FRAME);
      end
      checks++;
      if (car_x_obs() !== e.x) begin
        failures++; $display("FAIL midrst_x tick=%0d got=%h required=%h", i, car_x_obs(), e.x);
      end
      @(negedge clk);
    end
    checks++;
    if (o_Car_1X_Position !== 10'd8) begin
      failures++; $display("FAIL midrst_first_move got=%0d required=8", o_Car_1X_Position);
    end
  endtask

  initial begin
    test_reset();
    test_rates();
    test_level();
    test_wrap();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
